// File: rtl/regfile_multiport_if.sv
// Bus bundle for regfile_multiport: one write port, NRD packed read ports, status.
//   master : drives Wadd / Wdata / isWreg / Radd, receives Rdata / ready / wr_drop
//   slave  : register-file side of the same signals
interface regfile_multiport_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2
);
    logic [ADDR_W-1:0]     Wadd;
    logic [DATA_W-1:0]     Wdata;
    logic                  isWreg;
    logic [NRD*ADDR_W-1:0] Radd;
    logic [NRD*DATA_W-1:0] Rdata;
    logic                  ready;
    logic                  wr_drop;

    modport master (
        output Wadd,
        output Wdata,
        output isWreg,
        output Radd,
        input  Rdata,
        input  ready,
        input  wr_drop
    );

    modport slave (
        input  Wadd,
        input  Wdata,
        input  isWreg,
        input  Radd,
        output Rdata,
        output ready,
        output wr_drop
    );
endinterface

// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file: one clocked write port, NRD
// combinational read ports, optional hardwired-zero x0 and write-to-read
// bypass. After reset a sequencer zeroes one register per cycle and then
// raises ready.
//   clk          : clock, rising-edge
//   rstn         : asynchronous active-low reset
//   bus.Wadd     : write address
//   bus.Wdata    : write data
//   bus.isWreg   : write enable
//   bus.Radd     : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   bus.Rdata    : packed read data (combinational), port i at [i*DATA_W +: DATA_W]
//   bus.ready    : registered, 1 once the clear sequence has finished
//   bus.wr_drop  : registered one-cycle pulse for a write requested while clearing
module regfile_multiport #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic               clk,
    input  logic               rstn,
    regfile_multiport_if.slave bus
);
    localparam int unsigned NREGS = 2 ** ADDR_W;
    // One extra bit so the terminal count never wraps back to zero.
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e            state_q,   state_d;
    logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              ready_q,   ready_d;
    logic              wr_drop_q, wr_drop_d;

    logic [DATA_W-1:0] regf_q [NREGS];

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;

    logic [NRD*DATA_W-1:0] rdata_c;

    // Control state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Next state, clear sequencer and steering of the single array write port
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        wr_drop_d = 1'b0;
        arr_we    = 1'b0;
        arr_waddr = bus.Wadd;
        arr_wdata = bus.Wdata;

        case (state_q)
            ST_CLEAR: begin
                // The sequencer owns the write port; user writes are dropped.
                arr_we    = 1'b1;
                arr_waddr = clr_cnt_q[ADDR_W-1:0];
                arr_wdata = '0;
                clr_cnt_d = clr_cnt_q + CNT_W'(1);
                wr_drop_d = bus.isWreg;
                if (clr_cnt_q == CNT_W'(NREGS - 1)) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Writes to a hardwired x0 vanish without raising wr_drop.
                arr_we = bus.isWreg && !((ZERO_REG != 0) && (bus.Wadd == '0));
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Storage array; deliberately not reset, the sequencer clears it.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            regf_q[arr_waddr] <= arr_wdata;
        end
    end

    // Combinational read ports, each resolved independently
    always_comb begin
        rdata_c = '0;
        if (state_q == ST_RUN) begin
            for (int unsigned i = 0; i < NRD; i++) begin
                if ((ZERO_REG != 0) && (bus.Radd[i*ADDR_W +: ADDR_W] == '0)) begin
                    rdata_c[i*DATA_W +: DATA_W] = '0;
                end else if ((BYPASS != 0) && bus.isWreg &&
                             (bus.Radd[i*ADDR_W +: ADDR_W] == bus.Wadd)) begin
                    rdata_c[i*DATA_W +: DATA_W] = bus.Wdata;
                end else begin
                    rdata_c[i*DATA_W +: DATA_W] = regf_q[bus.Radd[i*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    assign bus.Rdata   = rdata_c;
    assign bus.ready   = ready_q;
    assign bus.wr_drop = wr_drop_q;

endmodule
